// File: rtl/if_stage_if.sv
// Instruction-memory request bus between the fetch stage and instruction memory.
// A single request is open at a time: imem_req/imem_addr are held until imem_ready.
interface if_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_rdata,
      input  imem_ready
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_rdata,
      output imem_ready
   );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, fetches over the imem bus and fills the
// IF/ID register. It honours hazard stalls and downstream redirects. A fetch that
// completes during a stall is parked in a one-word buffer. A fetch made stale by
// a redirect that arrived while it was still outstanding is dropped.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         redirect_valid,
   input  logic [31:0]  redirect_pc,
   if_stage_if.master   imem,
   output logic         if_id_valid,
   output logic [31:0]  if_id_instr,
   output logic [31:0]  if_id_pc4,
   output logic [5:0]   opcode,
   output logic [5:0]   func
);

   typedef enum logic {FETCH, HOLD} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        pendRedir_q, pendRedir_d;
   logic [31:0] pendPc_q, pendPc_d;
   logic [31:0] bufInstr_q, bufInstr_d;
   logic [31:0] bufPc4_q, bufPc4_d;
   logic        ifIdValid_q, ifIdValid_d;
   logic [31:0] ifIdInstr_q, ifIdInstr_d;
   logic [31:0] ifIdPc4_q, ifIdPc4_d;

   logic [31:0] pcPlus4;
   logic [31:0] redirTarget;

   assign pcPlus4     = pc_q + 32'd4;
   assign redirTarget = {redirect_pc[31:2], 2'b00};

   assign imem.imem_req  = (state_q == FETCH) && !reset;
   assign imem.imem_addr = pc_q;

   assign if_id_valid = ifIdValid_q;
   assign if_id_instr = ifIdInstr_q;
   assign if_id_pc4   = ifIdPc4_q;
   assign opcode      = ifIdInstr_q[31:26];
   assign func        = ifIdInstr_q[5:0];

   // Next-state logic: choose the next PC, the IF/ID contents and the buffer/pending-redirect bookkeeping.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      pendRedir_d = pendRedir_q;
      pendPc_d    = pendPc_q;
      bufInstr_d  = bufInstr_q;
      bufPc4_d    = bufPc4_q;
      ifIdValid_d = ifIdValid_q;
      ifIdInstr_d = ifIdInstr_q;
      ifIdPc4_d   = ifIdPc4_q;

      unique case (state_q)
         FETCH: begin
            if (imem.imem_ready) begin
               if (redirect_valid) begin
                  pc_d        = redirTarget;
                  pendRedir_d = 1'b0;
                  ifIdValid_d = 1'b0;
                  ifIdInstr_d = 32'd0;
               end else if (pendRedir_q) begin
                  pc_d        = pendPc_q;
                  pendRedir_d = 1'b0;
                  if (!stall) begin
                     ifIdValid_d = 1'b0;
                     ifIdInstr_d = 32'd0;
                  end
               end else if (!stall) begin
                  ifIdValid_d = 1'b1;
                  ifIdInstr_d = imem.imem_rdata;
                  ifIdPc4_d   = pcPlus4;
                  pc_d        = pcPlus4;
               end else begin
                  bufInstr_d = imem.imem_rdata;
                  bufPc4_d   = pcPlus4;
                  pc_d       = pcPlus4;
                  state_d    = HOLD;
               end
            end else begin
               if (redirect_valid) begin
                  pendRedir_d = 1'b1;
                  pendPc_d    = redirTarget;
                  ifIdValid_d = 1'b0;
                  ifIdInstr_d = 32'd0;
               end else if (!stall) begin
                  ifIdValid_d = 1'b0;
                  ifIdInstr_d = 32'd0;
               end
            end
         end
         HOLD: begin
            if (redirect_valid) begin
               pc_d        = redirTarget;
               ifIdValid_d = 1'b0;
               ifIdInstr_d = 32'd0;
               state_d     = FETCH;
            end else if (!stall) begin
               ifIdValid_d = 1'b1;
               ifIdInstr_d = bufInstr_q;
               ifIdPc4_d   = bufPc4_q;
               state_d     = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   // State registers with synchronous reset; reset abandons any outstanding fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         pendRedir_q <= 1'b0;
         pendPc_q    <= 32'd0;
         bufInstr_q  <= 32'd0;
         bufPc4_q    <= 32'd0;
         ifIdValid_q <= 1'b0;
         ifIdInstr_q <= 32'd0;
         ifIdPc4_q   <= 32'd0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         pendRedir_q <= pendRedir_d;
         pendPc_q    <= pendPc_d;
         bufInstr_q  <= bufInstr_d;
         bufPc4_q    <= bufPc4_d;
         ifIdValid_q <= ifIdValid_d;
         ifIdInstr_q <= ifIdInstr_d;
         ifIdPc4_q   <= ifIdPc4_d;
      end
   end

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage. Instruction memory is a small lookup
// function that answers combinationally whenever the bench raises imem_ready.
module tb_if_stage;

   logic        clk;
   logic        reset;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        if_id_valid;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic [5:0]  opcode;
   logic [5:0]  func;

   int testsRun;
   int testsFailed;

   if_stage_if bus ();

   if_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem           (bus.master),
      .if_id_valid    (if_id_valid),
      .if_id_instr    (if_id_instr),
      .if_id_pc4      (if_id_pc4),
      .opcode         (opcode),
      .func           (func)
   );

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] memWord(input logic [31:0] addr);
      case (addr)
         32'h0000_0000: memWord = 32'h2008_0005;
         32'h0000_0004: memWord = 32'h8D09_0000;
         32'h0000_0008: memWord = 32'h0109_5020;
         32'h0000_000C: memWord = 32'hAC0A_0004;
         32'h0000_0040: memWord = 32'h0C00_0010;
         32'h0000_0044: memWord = 32'h1109_FFFE;
         default:       memWord = ~addr;
      endcase
   endfunction

   assign bus.imem_rdata = memWord(bus.imem_addr);

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
      bus.imem_ready = 1'b0;
      step();
      step();
      testsRun++;
      if ({bus.imem_req, if_id_valid, if_id_instr, if_id_pc4, bus.imem_addr} !== {1'b0, 1'b0, 32'd0, 32'd0, 32'd0}) begin
         testsFailed++;
         $display("[TB] FAIL reset_state: req=%b valid=%b instr=%h pc4=%h addr=%h, expected all zero",
                  bus.imem_req, if_id_valid, if_id_instr, if_id_pc4, bus.imem_addr);
      end
      reset = 1'b0;
      #1;
      testsRun++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
         testsFailed++;
         $display("[TB] FAIL first_req: req=%b addr=%h, expected req=1 addr=00000000", bus.imem_req, bus.imem_addr);
      end
   endtask

   task automatic test_sequential();
      bus.imem_ready = 1'b1;
      step();
      testsRun++;
      if ({if_id_valid, if_id_instr, if_id_pc4, opcode, bus.imem_addr} !== {1'b1, 32'h2008_0005, 32'h4, 6'h08, 32'h4}) begin
         testsFailed++;
         $display("[TB] FAIL seq_word0: valid=%b instr=%h pc4=%h op=%h addr=%h, expected 1 20080005 00000004 08 00000004",
                  if_id_valid, if_id_instr, if_id_pc4, opcode, bus.imem_addr);
      end
      step();
      testsRun++;
      if ({if_id_valid, if_id_instr, if_id_pc4, opcode, func, bus.imem_addr} !== {1'b1, 32'h8D09_0000, 32'h8, 6'h23, 6'h00, 32'h8}) begin
         testsFailed++;
         $display("[TB] FAIL seq_word1: valid=%b instr=%h pc4=%h op=%h func=%h addr=%h, expected 1 8d090000 00000008 23 00 00000008",
                  if_id_valid, if_id_instr, if_id_pc4, opcode, func, bus.imem_addr);
      end
   endtask

   task automatic test_wait_states();
      bus.imem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         testsRun++;
         if ({bus.imem_req, if_id_valid, bus.imem_addr} !== {1'b1, 1'b0, 32'h8}) begin
            testsFailed++;
            $display("[TB] FAIL wait_bubble%0d: req=%b valid=%b addr=%h, expected 1 0 00000008",
                     i, bus.imem_req, if_id_valid, bus.imem_addr);
         end
      end
      bus.imem_ready = 1'b1;
      step();
      testsRun++;
      if ({if_id_valid, if_id_instr, if_id_pc4, func, bus.imem_addr} !== {1'b1, 32'h0109_5020, 32'hC, 6'h20, 32'hC}) begin
         testsFailed++;
         $display("[TB] FAIL wait_word: valid=%b instr=%h pc4=%h func=%h addr=%h, expected 1 01095020 0000000c 20 0000000c",
                  if_id_valid, if_id_instr, if_id_pc4, func, bus.imem_addr);
      end
   endtask

   task automatic test_stall_hold();
      stall = 1'b1;
      bus.imem_ready = 1'b1;
      step();
      bus.imem_ready = 1'b0;
      testsRun++;
      if ({bus.imem_req, if_id_valid, if_id_instr, if_id_pc4} !== {1'b0, 1'b1, 32'h0109_5020, 32'hC}) begin
         testsFailed++;
         $display("[TB] FAIL stall_capture: req=%b valid=%b instr=%h pc4=%h, expected 0 1 01095020 0000000c",
                  bus.imem_req, if_id_valid, if_id_instr, if_id_pc4);
      end
      step();
      testsRun++;
      if ({bus.imem_req, if_id_valid, if_id_instr, if_id_pc4} !== {1'b0, 1'b1, 32'h0109_5020, 32'hC}) begin
         testsFailed++;
         $display("[TB] FAIL stall_hold: req=%b valid=%b instr=%h pc4=%h, expected 0 1 01095020 0000000c",
                  bus.imem_req, if_id_valid, if_id_instr, if_id_pc4);
      end
      stall = 1'b0;
      step();
      testsRun++;
      if ({bus.imem_req, if_id_valid, if_id_instr, if_id_pc4, bus.imem_addr} !== {1'b1, 1'b1, 32'hAC0A_0004, 32'h10, 32'h10}) begin
         testsFailed++;
         $display("[TB] FAIL stall_release: req=%b valid=%b instr=%h pc4=%h addr=%h, expected 1 1 ac0a0004 00000010 00000010",
                  bus.imem_req, if_id_valid, if_id_instr, if_id_pc4, bus.imem_addr);
      end
   endtask

   task automatic test_pending_redirect();
      bus.imem_ready = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc = 32'h40;
      step();
      redirect_valid = 1'b0;
      testsRun++;
      if ({bus.imem_req, if_id_valid, if_id_instr, bus.imem_addr} !== {1'b1, 1'b0, 32'd0, 32'h10}) begin
         testsFailed++;
         $display("[TB] FAIL pend_flush: req=%b valid=%b instr=%h addr=%h, expected 1 0 00000000 00000010",
                  bus.imem_req, if_id_valid, if_id_instr, bus.imem_addr);
      end
      step();
      bus.imem_ready = 1'b1;
      step();
      testsRun++;
      if ({if_id_valid, if_id_instr, bus.imem_addr} !== {1'b0, 32'd0, 32'h40}) begin
         testsFailed++;
         $display("[TB] FAIL pend_discard: valid=%b instr=%h addr=%h, expected 0 00000000 00000040",
                  if_id_valid, if_id_instr, bus.imem_addr);
      end
      step();
      testsRun++;
      if ({if_id_valid, if_id_instr, if_id_pc4, opcode, bus.imem_addr} !== {1'b1, 32'h0C00_0010, 32'h44, 6'h03, 32'h44}) begin
         testsFailed++;
         $display("[TB] FAIL pend_target: valid=%b instr=%h pc4=%h op=%h addr=%h, expected 1 0c000010 00000044 03 00000044",
                  if_id_valid, if_id_instr, if_id_pc4, opcode, bus.imem_addr);
      end
   endtask

   task automatic test_hold_redirect();
      stall = 1'b1;
      bus.imem_ready = 1'b1;
      step();
      bus.imem_ready = 1'b0;
      testsRun++;
      if ({bus.imem_req, if_id_instr} !== {1'b0, 32'h0C00_0010}) begin
         testsFailed++;
         $display("[TB] FAIL hold_enter: req=%b instr=%h, expected 0 0c000010", bus.imem_req, if_id_instr);
      end
      redirect_valid = 1'b1;
      redirect_pc = 32'h103;
      step();
      redirect_valid = 1'b0;
      stall = 1'b0;
      testsRun++;
      if ({bus.imem_req, if_id_valid, if_id_instr, bus.imem_addr} !== {1'b1, 1'b0, 32'd0, 32'h100}) begin
         testsFailed++;
         $display("[TB] FAIL hold_redirect: req=%b valid=%b instr=%h addr=%h, expected 1 0 00000000 00000100",
                  bus.imem_req, if_id_valid, if_id_instr, bus.imem_addr);
      end
      bus.imem_ready = 1'b1;
      step();
      testsRun++;
      if ({if_id_valid, if_id_instr, if_id_pc4} !== {1'b1, 32'hFFFF_FEFF, 32'h104}) begin
         testsFailed++;
         $display("[TB] FAIL hold_buf_dropped: valid=%b instr=%h pc4=%h, expected 1 fffffeff 00000104",
                  if_id_valid, if_id_instr, if_id_pc4);
      end
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      step();
      redirect_valid = 1'b0;
      testsRun++;
      if ({if_id_valid, bus.imem_addr} !== {1'b0, 32'hFFFF_FFFC}) begin
         testsFailed++;
         $display("[TB] FAIL wrap_redirect: valid=%b addr=%h, expected 0 fffffffc", if_id_valid, bus.imem_addr);
      end
      step();
      testsRun++;
      if ({if_id_valid, if_id_instr, if_id_pc4, bus.imem_addr} !== {1'b1, 32'h0000_0003, 32'h0, 32'h0}) begin
         testsFailed++;
         $display("[TB] FAIL wrap_pc4: valid=%b instr=%h pc4=%h addr=%h, expected 1 00000003 00000000 00000000",
                  if_id_valid, if_id_instr, if_id_pc4, bus.imem_addr);
      end
   endtask

   task automatic test_reset_mid_fetch();
      step();
      bus.imem_ready = 1'b0;
      step();
      testsRun++;
      if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h4}) begin
         testsFailed++;
         $display("[TB] FAIL midreset_pending: req=%b addr=%h, expected 1 00000004", bus.imem_req, bus.imem_addr);
      end
      reset = 1'b1;
      #1;
      testsRun++;
      if (bus.imem_req !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL midreset_req_drop: req=%b, expected 0", bus.imem_req);
      end
      step();
      testsRun++;
      if ({bus.imem_req, if_id_valid, if_id_instr, if_id_pc4, opcode, func, bus.imem_addr} !== {1'b0, 1'b0, 32'd0, 32'd0, 6'd0, 6'd0, 32'd0}) begin
         testsFailed++;
         $display("[TB] FAIL midreset_outputs: req=%b valid=%b instr=%h pc4=%h op=%h func=%h addr=%h, expected all zero",
                  bus.imem_req, if_id_valid, if_id_instr, if_id_pc4, opcode, func, bus.imem_addr);
      end
      reset = 1'b0;
      bus.imem_ready = 1'b1;
      step();
      testsRun++;
      if ({if_id_valid, if_id_instr, if_id_pc4, bus.imem_addr} !== {1'b1, 32'h2008_0005, 32'h4, 32'h4}) begin
         testsFailed++;
         $display("[TB] FAIL midreset_refetch: valid=%b instr=%h pc4=%h addr=%h, expected 1 20080005 00000004 00000004",
                  if_id_valid, if_id_instr, if_id_pc4, bus.imem_addr);
      end
   endtask

   // Scenario sequence; each task leaves the DUT in the state the next one expects.
   initial begin
      testsRun = 0;
      testsFailed = 0;
      test_reset();
      test_sequential();
      test_wait_states();
      test_stall_hold();
      test_pending_redirect();
      test_hold_redirect();
      test_wrap();
      test_reset_mid_fetch();
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
